// File: rtl/jpeg_fmt_pkg.sv
// Shared definitions for the JPEG-2000 sign-format conversion datapath:
// conversion mode codes and a width-generic saturate/encode helper.
package jpeg_fmt_pkg;

    // Per-sample conversion selector, carried alongside each sample
    typedef enum logic [1:0] {
        FMT_SM2TC = 2'd0,
        FMT_TC2SM = 2'd1,
        FMT_TC2TC = 2'd2,
        FMT_OB2TC = 2'd3
    } fmt_mode_t;

    // Working width of the helper; any IN_W/OUT_W up to this fits
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic [SAT_MAX_W-1:0] data;   // encoded result, valid in the low out_w bits
        logic                 sat;    // clamping changed the value
    } sat_res_t;

    // Saturate a signed value to out_w bits and encode it either as two's
    // complement (sm_out=0) or sign-magnitude (sm_out=1). In sign-magnitude
    // the sign bit is only set for strictly negative values, so negative
    // zero can never be produced.
    function automatic sat_res_t sat_encode(
        input logic signed [SAT_MAX_W-1:0] v,
        input int                          out_w,
        input logic                        sm_out
    );
        logic signed [SAT_MAX_W-1:0] max_pos;
        logic signed [SAT_MAX_W-1:0] min_neg;
        logic signed [SAT_MAX_W-1:0] mag;
        logic        [SAT_MAX_W-1:0] sign_bit;
        logic                        v_neg;
        sat_res_t                    r;

        max_pos  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_neg  = -(64'sd1 <<< (out_w - 1));
        sign_bit = 64'd1 << (out_w - 1);
        v_neg    = v[SAT_MAX_W-1];
        r        = '0;
        mag      = '0;

        if (sm_out) begin
            mag = v_neg ? -v : v;
            if (mag > max_pos) begin
                mag   = max_pos;
                r.sat = 1'b1;
            end
            r.data = mag | (v_neg ? sign_bit : '0);
        end else begin
            if (v > max_pos) begin
                r.data = max_pos;
                r.sat  = 1'b1;
            end else if (v < min_neg) begin
                r.data = min_neg;
                r.sat  = 1'b1;
            end else begin
                r.data = v;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/signed_fmt_sat.sv
// Combinational saturate/encode of a signed value V to OUT_W bits,
// two's-complement or sign-magnitude, with a saturation flag.
module signed_fmt_sat
    import jpeg_fmt_pkg::*;
#(
    parameter int V_W   = 11,
    parameter int OUT_W = 9
) (
    input  logic signed [V_W-1:0]   v,
    input  logic                    sm_out,
    output logic        [OUT_W-1:0] data,
    output logic                    sat
);

    logic signed [SAT_MAX_W-1:0] v_ext;
    sat_res_t                    res;
    logic                        unused_hi;

    // Sign-extend into the helper's working width and encode
    always_comb begin
        v_ext     = {{(SAT_MAX_W-V_W){v[V_W-1]}}, v};
        res       = sat_encode(v_ext, OUT_W, sm_out);
        data      = res.data[OUT_W-1:0];
        sat       = res.sat;
        // Bits above OUT_W are only sign copies and are deliberately dropped
        unused_hi = ^res.data[SAT_MAX_W-1:OUT_W];
    end

endmodule

// File: rtl/signed_format_converter.sv
// Streaming sign-format converter: stage 1 decodes the input sample to a
// signed value V, stage 2 saturates/encodes it to OUT_W. Valid/ready
// handshake with full backpressure and a sticky saturation counter.
module signed_format_converter
    import jpeg_fmt_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    input  logic             clr_count,
    output logic [CNT_W-1:0] sat_count
);

    localparam int VW = IN_W + 1;
    // DC level shift for offset-binary input: 2^(IN_W-1)
    localparam logic signed [VW-1:0] OB_OFFSET = {2'b01, {(IN_W-1){1'b0}}};

    logic                    s1_valid_q, s1_valid_d;
    logic signed [VW-1:0]    s1_v_q, s1_v_d;
    fmt_mode_t               s1_mode_q, s1_mode_d;
    logic                    s2_valid_q, s2_valid_d;
    logic        [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;
    logic        [CNT_W-1:0] sat_count_q, sat_count_d;

    logic signed [VW-1:0]    dec_v;
    logic signed [VW-1:0]    sm_mag;
    logic        [OUT_W-1:0] enc_data;
    logic                    enc_sat;
    logic                    s1_load;
    logic                    s2_load;

    // Stage-1 decode of the incoming sample to a signed value
    always_comb begin
        sm_mag = {2'b00, in_data[IN_W-2:0]};
        dec_v  = {in_data[IN_W-1], in_data};
        case (fmt_mode_t'(mode))
            FMT_SM2TC: dec_v = in_data[IN_W-1] ? -sm_mag : sm_mag;
            FMT_OB2TC: dec_v = $signed({1'b0, in_data}) - OB_OFFSET;
            default:   dec_v = {in_data[IN_W-1], in_data};
        endcase
    end

    // Stage-2 saturate/encode of the value held in stage 1
    signed_fmt_sat #(
        .V_W   (VW),
        .OUT_W (OUT_W)
    ) u_sat (
        .v      (s1_v_q),
        .sm_out (s1_mode_q == FMT_TC2SM),
        .data   (enc_data),
        .sat    (enc_sat)
    );

    // A stage loads when it is empty or its contents move forward this cycle
    always_comb begin
        s2_load = ~s2_valid_q | out_ready;
        s1_load = ~s1_valid_q | s2_load;
    end

    assign in_ready  = s1_load;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

    // Next-state for both pipeline stages and the saturation counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_v_d      = s1_v_q;
        s1_mode_d   = s1_mode_q;
        s2_valid_d  = s2_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        sat_count_d = sat_count_q;

        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_v_d    = dec_v;
                s1_mode_d = fmt_mode_t'(mode);
            end
        end

        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = enc_data;
                out_sat_d  = enc_sat;
            end
        end

        // Clear wins over a coincident increment; count sticks at all-ones
        if (clr_count) begin
            sat_count_d = '0;
        end else if (s2_valid_q && out_ready && out_sat_q && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    // Pipeline and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_v_q      <= '0;
            s1_mode_q   <= FMT_SM2TC;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_v_q      <= s1_v_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

endmodule

// File: tb/tb_signed_format_converter.sv
// Self-checking bench for signed_format_converter (IN_W=10, OUT_W=9):
// directed vector table, random mixed-mode stream with backpressure,
// counter saturation/clear and mid-stream reset sequences.
module tb_signed_format_converter;

    localparam int IN_W  = 10;
    localparam int OUT_W = 9;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             clr_count;
    logic [CNT_W-1:0] sat_count;

    signed_format_converter #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .clr_count (clr_count),
        .sat_count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  din;
        logic [OUT_W-1:0] exp_data;
        logic             exp_sat;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             s;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   model_cnt = 0;
    bit   bp_en     = 1'b0;
    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Integer reference model of decode + saturate + encode
    function automatic exp_t model(input logic [1:0] m, input logic [IN_W-1:0] din);
        int   v;
        int   mag;
        int   word;
        int   lim_hi;
        int   lim_lo;
        exp_t r;
        lim_hi = (1 << (OUT_W-1)) - 1;
        lim_lo = -(1 << (OUT_W-1));
        case (m)
            2'd0: begin
                mag = int'(din[IN_W-2:0]);
                v   = din[IN_W-1] ? -mag : mag;
            end
            2'd3:    v = int'(din) - (1 << (IN_W-1));
            default: v = din[IN_W-1] ? int'(din) - (1 << IN_W) : int'(din);
        endcase
        r.s = 1'b0;
        if (m == 2'd1) begin
            mag = (v < 0) ? -v : v;
            if (mag > lim_hi) begin
                mag = lim_hi;
                r.s = 1'b1;
            end
            word = mag + ((v < 0) ? (1 << (OUT_W-1)) : 0);
            r.d  = OUT_W'(word);
        end else begin
            if (v > lim_hi) begin
                v   = lim_hi;
                r.s = 1'b1;
            end else if (v < lim_lo) begin
                v   = lim_lo;
                r.s = 1'b1;
            end
            r.d = OUT_W'(v);
        end
        return r;
    endfunction

    // Random backpressure, driven just after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Output monitor: scoreboard pop, stall stability, model counter
    logic [OUT_W-1:0] held_d;
    logic             held_s;
    bit               held_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v    = 1'b0;
            model_cnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected no output", out_data);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_sat", 64'(out_sat), 64'(e.s));
                    if (clr_count) model_cnt = 0;
                    else if (e.s && model_cnt != 65535) model_cnt++;
                end
            end else if (clr_count) begin
                model_cnt = 0;
            end
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    check("stall_data", 64'(out_data), 64'(held_d));
                    check("stall_sat", 64'(out_sat), 64'(held_s));
                end
                held_d = out_data;
                held_s = out_sat;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Present one sample (called #1 after a rising edge) and wait for accept
    task automatic send(input logic [1:0] m, input logic [IN_W-1:0] d, input exp_t e);
        int n;
        mode     = m;
        in_data  = d;
        in_valid = 1'b1;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end else begin
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the scoreboard to empty, bounded
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [1:0]      m;
        logic [IN_W-1:0] d;

        vecs[0]  = '{2'd0, 10'h201, 9'h1FF, 1'b0};
        vecs[1]  = '{2'd0, 10'h3FF, 9'h100, 1'b1};
        vecs[2]  = '{2'd0, 10'h0FF, 9'h0FF, 1'b0};
        vecs[3]  = '{2'd0, 10'h100, 9'h0FF, 1'b1};
        vecs[4]  = '{2'd1, 10'h3FF, 9'h101, 1'b0};
        vecs[5]  = '{2'd1, 10'h3FB, 9'h105, 1'b0};
        vecs[6]  = '{2'd1, 10'h300, 9'h1FF, 1'b1};
        vecs[7]  = '{2'd1, 10'h000, 9'h000, 1'b0};
        vecs[8]  = '{2'd3, 10'h200, 9'h000, 1'b0};
        vecs[9]  = '{2'd3, 10'h201, 9'h001, 1'b0};
        vecs[10] = '{2'd3, 10'h000, 9'h100, 1'b1};
        vecs[11] = '{2'd3, 10'h3FF, 9'h0FF, 1'b1};
        vecs[12] = '{2'd0, 10'h200, 9'h000, 1'b0};

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        mode      = 2'd0;
        in_data   = '0;
        #3 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        check("rst_sat_count", 64'(sat_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // First-sample latency: accepted at the next edge, visible two cycles on
        @(posedge clk);
        #1;
        mode     = 2'd0;
        in_data  = 10'h001;
        in_valid = 1'b1;
        e = '{9'h001, 1'b0};
        sb_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("latency_cycle2_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Directed vector table, back-to-back with out_ready high
        for (int i = 0; i < 13; i++) begin
            e = '{vecs[i].exp_data, vecs[i].exp_sat};
            send(vecs[i].mode, vecs[i].din, e);
        end
        drain(50);
        check("sat_count_directed", 64'(sat_count), 64'd5);

        // Random mixed-mode stream under 50% backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            m = 2'($urandom_range(0, 3));
            d = IN_W'($urandom_range(0, (1 << IN_W) - 1));
            send(m, d, model(m, d));
        end
        drain(5000);
        bp_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("sat_count_random", 64'(sat_count), 64'(model_cnt));

        // Clear on its own
        clr_count = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        check("sat_count_clear", 64'(sat_count), 64'd0);

        // Drive the counter to 0xFFFE, then confirm it sticks at all-ones
        e = '{9'h100, 1'b1};
        for (int i = 0; i < 65534; i++) send(2'd3, 10'h000, e);
        drain(50);
        check("sat_count_fffe", 64'(sat_count), 64'hFFFE);
        for (int i = 0; i < 3; i++) send(2'd3, 10'h000, e);
        drain(50);
        check("sat_count_sticky", 64'(sat_count), 64'hFFFF);
        check("sat_count_model", 64'(sat_count), 64'(model_cnt));

        // Clear coincident with a saturated transfer
        out_ready = 1'b0;
        send(2'd0, 10'h3FF, '{9'h100, 1'b1});
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        check("stalled_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        clr_count = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        check("clr_with_sat_transfer", 64'(sat_count), 64'd0);
        check("clr_queue_empty", 64'(sb_q.size()), 64'd0);

        // Reset with both stages full and output stalled
        out_ready = 1'b0;
        send(2'd2, 10'h005, '{9'h005, 1'b0});
        send(2'd2, 10'h006, '{9'h006, 1'b0});
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2'd2, 10'h007, '{9'h007, 1'b0});
        drain(20);
        repeat (4) begin
            @(negedge clk);
            check("postrst_idle_valid", 64'(out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
